// File: rtl/pem_serial_regfile_if.sv
// Serial control bus between a host (master) and the register-bank model (slave).
// ENABLE is an active-low frame window; SCANOUT carries readback data.
interface pem_serial_regfile_if;
  logic ENABLE;
  logic DATA;
  logic SCANOUT;
  logic FRAME_ERR;

  modport master (
    output ENABLE,
    output DATA,
    input  SCANOUT,
    input  FRAME_ERR
  );

  modport slave (
    input  ENABLE,
    input  DATA,
    output SCANOUT,
    output FRAME_ERR
  );
endinterface

// File: rtl/pem_serial_regfile.sv
// Serially programmed register bank: shifts host frames in during the ENABLE-low window,
// commits on the rising edge of ENABLE, and streams readback words on SCANOUT.
module pem_serial_regfile #(
  parameter int              DATA_W     = 8,
  parameter int              ADDR_W     = 4,
  parameter int              ID_W       = 3,
  parameter logic [ID_W-1:0] ID_CODE    = 3'b110,
  parameter bit              RD_AUTOINC = 1'b1
) (
  input  logic                           CLOCK,
  input  logic                           RESET,
  pem_serial_regfile_if.slave            bus,
  output logic [(2**ADDR_W)*DATA_W-1:0]  REGS
);

  localparam int DEPTH   = 2**ADDR_W;
  localparam int FRAME_W = DATA_W + ADDR_W + ID_W + 3;
  localparam int CNT_W   = $clog2(FRAME_W + 2);
  localparam int BIT_W   = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  typedef enum logic {
    ST_IDLE,
    ST_WIN
  } state_t;

  state_t               r_state;
  state_t               w_state_next;
  logic                 w_commit;
  logic                 w_shift;

  logic [FRAME_W-1:0]   r_in_sh;
  logic [CNT_W-1:0]     r_cnt;
  logic [DATA_W-1:0]    r_mem [DEPTH];
  logic [DATA_W-1:0]    r_out_sh;
  logic [ADDR_W-1:0]    r_ptr;
  logic [BIT_W-1:0]     r_bit_cnt;
  logic                 r_rd_active;
  logic                 r_frame_err;

  logic [ID_W-1:0]      w_id;
  logic                 w_op;
  logic [ADDR_W-1:0]    w_addr;
  logic [1:0]           w_mbz;
  logic [DATA_W-1:0]    w_data;
  logic                 w_id_hit;
  logic                 w_reject;
  logic                 w_wr;
  logic                 w_rd;

  // Window tracker: the first posedge with ENABLE high after a low window is the commit edge.
  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_commit     = 1'b0;
    w_shift      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!bus.ENABLE) begin
          w_shift      = 1'b1;
          w_state_next = ST_WIN;
        end
      end
      ST_WIN: begin
        if (bus.ENABLE) begin
          w_commit     = 1'b1;
          w_state_next = ST_IDLE;
        end else begin
          w_shift      = 1'b1;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Field layout, LSB up: id, op, addr, two must-be-zero bits, data.
  assign w_id   = r_in_sh[ID_W-1:0];
  assign w_op   = r_in_sh[ID_W];
  assign w_addr = r_in_sh[ID_W+1 +: ADDR_W];
  assign w_mbz  = r_in_sh[ID_W+1+ADDR_W +: 2];
  assign w_data = r_in_sh[FRAME_W-1 -: DATA_W];

  assign w_id_hit = w_commit && (r_cnt != '0) && (w_id == ID_CODE);
  assign w_reject = w_id_hit && ((r_cnt != CNT_W'(FRAME_W)) || (w_mbz != 2'b00));
  assign w_wr     = w_id_hit && !w_reject && w_op;
  assign w_rd     = w_id_hit && !w_reject && !w_op;

  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      r_in_sh <= '0;
      r_cnt   <= '0;
    end else if (w_commit) begin
      r_in_sh <= '0;
      r_cnt   <= '0;
    end else if (w_shift) begin
      r_in_sh <= {r_in_sh[FRAME_W-2:0], bus.DATA};
      if (r_cnt != CNT_W'(FRAME_W + 1)) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_wr) begin
      r_mem[w_addr] <= w_data;
    end
  end

  // The word already in r_out_sh is a snapshot, so a write to its address does not
  // disturb bits currently shifting out; only later burst loads see the new value.
  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      r_rd_active <= 1'b0;
      r_out_sh    <= '0;
      r_ptr       <= '0;
      r_bit_cnt   <= '0;
    end else if (w_commit) begin
      r_rd_active <= w_rd;
      if (w_rd) begin
        r_out_sh  <= r_mem[w_addr];
        r_ptr     <= w_addr + 1'b1;
        r_bit_cnt <= '0;
      end
    end else if (w_shift && r_rd_active) begin
      if (RD_AUTOINC && (r_bit_cnt == BIT_W'(DATA_W - 1))) begin
        r_out_sh  <= r_mem[r_ptr];
        r_ptr     <= r_ptr + 1'b1;
        r_bit_cnt <= '0;
      end else begin
        r_out_sh  <= {r_out_sh[DATA_W-2:0], 1'b0};
        r_bit_cnt <= r_bit_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      r_frame_err <= 1'b0;
    end else begin
      r_frame_err <= w_reject;
    end
  end

  assign bus.FRAME_ERR = r_frame_err;
  assign bus.SCANOUT   = !bus.ENABLE && r_rd_active && r_out_sh[DATA_W-1];

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_regs
    assign REGS[gi*DATA_W +: DATA_W] = r_mem[gi];
  end

endmodule

// File: tb/tb_pem_serial_regfile.sv
// Randomized bench for pem_serial_regfile: two instances (burst and single-word readback)
// driven by the same frames and checked against a word-level model of the register bank.
module tb_pem_serial_regfile;
  localparam int         DW    = 8;
  localparam int         AW    = 4;
  localparam int         FW    = 18;
  localparam int         DEPTH = 16;
  localparam logic [2:0] MYID  = 3'b110;

  logic clk = 1'b0;
  logic rst;
  logic en;
  logic din;
  logic [DEPTH*DW-1:0] regs_a;
  logic [DEPTH*DW-1:0] regs_b;

  always #5 clk = ~clk;

  pem_serial_regfile_if bus_a ();
  pem_serial_regfile_if bus_b ();

  assign bus_a.ENABLE = en;
  assign bus_a.DATA   = din;
  assign bus_b.ENABLE = en;
  assign bus_b.DATA   = din;

  pem_serial_regfile #(.RD_AUTOINC(1'b1)) dut_a (
    .CLOCK (clk),
    .RESET (rst),
    .bus   (bus_a.slave),
    .REGS  (regs_a)
  );

  pem_serial_regfile #(.RD_AUTOINC(1'b0)) dut_b (
    .CLOCK (clk),
    .RESET (rst),
    .bus   (bus_b.slave),
    .REGS  (regs_b)
  );

  logic [7:0] m_regs [DEPTH];
  bit         m_rd;
  int         m_rd_addr;
  int         n_vec = 0;
  int         n_err = 0;
  int         n_frame = 0;

  task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s frame=%0d got=%0h exp=%0h", tag, n_frame, got, exp);
    end
  endtask

  function automatic logic [127:0] model_flat();
    logic [127:0] f;
    f = '0;
    for (int i = 0; i < DEPTH; i++) f[i*DW +: DW] = m_regs[i];
    return f;
  endfunction

  function automatic logic [31:0] mk(input logic [7:0] d, input logic [1:0] z,
                                     input logic [3:0] a, input logic op, input logic [2:0] id);
    return {14'b0, d, z, a, op, id};
  endfunction

  // Expected SCANOUT for bit i of the current window.
  function automatic logic exp_bit(input bit autoinc, input int i);
    logic [7:0] w;
    if (!m_rd) return 1'b0;
    if (autoinc) begin
      w = m_regs[(m_rd_addr + i / 8) % DEPTH];
      return w[7 - (i % 8)];
    end
    if (i >= 8) return 1'b0;
    w = m_regs[m_rd_addr];
    return w[7 - i];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) m_regs[i] = 8'h00;
    m_rd      = 1'b0;
    m_rd_addr = 0;
  endtask

  task automatic shift_bits(input logic [31:0] bits, input int len);
    for (int i = 0; i < len; i++) begin
      @(negedge clk);
      en  = 1'b0;
      din = bits[len-1-i];
      #1;
      check_val("scan_burst", {127'b0, bus_a.SCANOUT}, {127'b0, exp_bit(1'b1, i)});
      check_val("scan_single", {127'b0, bus_b.SCANOUT}, {127'b0, exp_bit(1'b0, i)});
    end
  endtask

  task automatic send(input logic [31:0] bits, input int len, input string what);
    logic [31:0] m;
    logic [2:0]  id;
    logic        op;
    logic [3:0]  addr;
    logic [1:0]  mbz;
    logic [7:0]  data;
    int          cnt;
    logic        exp_err;
    shift_bits(bits, len);
    @(negedge clk);
    en  = 1'b1;
    din = 1'b0;
    #1;
    check_val("scan_idle", {127'b0, bus_a.SCANOUT}, 128'd0);
    @(posedge clk);
    #1;
    m    = (len >= 32) ? bits : (bits & ((32'd1 << len) - 32'd1));
    id   = m[2:0];
    op   = m[3];
    addr = m[7:4];
    mbz  = m[9:8];
    data = m[17:10];
    cnt  = (len > FW + 1) ? FW + 1 : len;
    exp_err = 1'b0;
    m_rd    = 1'b0;
    if (cnt != 0 && id == MYID) begin
      if (cnt != FW || mbz != 2'b00) exp_err = 1'b1;
      else if (op) m_regs[addr] = data;
      else begin
        m_rd      = 1'b1;
        m_rd_addr = int'(addr);
      end
    end
    check_val("frame_err_a", {127'b0, bus_a.FRAME_ERR}, {127'b0, exp_err});
    check_val("frame_err_b", {127'b0, bus_b.FRAME_ERR}, {127'b0, exp_err});
    check_val("regs_a", regs_a, model_flat());
    check_val("regs_b", regs_b, model_flat());
    $display("frame %0d %s len=%0d bits=%05h err=%0d rd=%0d", n_frame, what, len, m, exp_err, m_rd);
    @(posedge clk);
    #1;
    check_val("frame_err_drop", {127'b0, bus_a.FRAME_ERR}, 128'd0);
    n_frame++;
  endtask

  initial begin
    logic [31:0] f;
    int          kind;
    int          len;

    rst = 1'b1;
    en  = 1'b1;
    din = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_val("reset_regs", regs_a, 128'd0);
    check_val("reset_err", {127'b0, bus_a.FRAME_ERR}, 128'd0);
    check_val("reset_scan", {127'b0, bus_a.SCANOUT}, 128'd0);
    @(negedge clk);
    rst = 1'b0;

    send(mk(8'hA5, 2'b00, 4'd3, 1'b1, MYID), 18, "wr3");
    send(mk(8'h3C, 2'b00, 4'd4, 1'b1, MYID), 18, "wr4");
    send(mk(8'h00, 2'b00, 4'd3, 1'b0, MYID), 18, "rd3");
    send(32'd0, 16, "zero_window");
    send(mk(8'h77, 2'b00, 4'd5, 1'b1, MYID), 17, "short17");
    f = mk(8'h77, 2'b00, 4'd5, 1'b1, MYID) | 32'h40000;
    send(f, 19, "long19");
    send(mk(8'h77, 2'b01, 4'd5, 1'b1, MYID), 18, "mbz01");
    send(mk(8'h55, 2'b00, 4'd6, 1'b1, 3'b111), 18, "foreign_id");
    send(mk(8'hE1, 2'b00, 4'd15, 1'b1, MYID), 18, "wr15");
    send(mk(8'h1E, 2'b00, 4'd0, 1'b1, MYID), 18, "wr0");
    send(mk(8'h00, 2'b00, 4'd15, 1'b0, MYID), 18, "rd15");
    send(32'd0, 16, "wrap_window");

    // Reset lands on the same edge the window would have committed.
    shift_bits(mk(8'hC3, 2'b00, 4'd9, 1'b1, MYID) >> 9, 9);
    @(negedge clk);
    en  = 1'b1;
    rst = 1'b1;
    #1;
    model_reset();
    check_val("midframe_rst_regs", regs_a, 128'd0);
    check_val("midframe_rst_scan", {127'b0, bus_a.SCANOUT}, 128'd0);
    @(posedge clk);
    #1;
    check_val("midframe_rst_err", {127'b0, bus_a.FRAME_ERR}, 128'd0);
    @(negedge clk);
    rst = 1'b0;
    send(mk(8'h5A, 2'b00, 4'd9, 1'b1, MYID), 18, "post_rst_wr9");
    send(mk(8'h00, 2'b00, 4'd9, 1'b0, MYID), 18, "post_rst_rd9");

    for (int n = 0; n < 160; n++) begin
      kind = int'($urandom_range(0, 9));
      f    = mk(8'($urandom), 2'b00, 4'($urandom), 1'($urandom), MYID);
      len  = 18;
      case (kind)
        0: begin
          len = int'($urandom_range(3, 32));
          f   = $urandom;
        end
        1: f[9:8] = 2'($urandom_range(1, 3));
        2: f[2:0] = 3'($urandom_range(0, 5));
        3: f[3]   = 1'b0;
        default: ;
      endcase
      send(f, len, "rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
